// File: rtl/fwperiph_dma_dbg_pkg.sv
// Shared types and constants for the DMA debug trace capture block.
// Includes the FSM encoding, trace entry layout and channel-enable helper.
package fwperiph_dma_dbg_pkg;

    localparam int ADR_W   = 32;
    localparam int DAT_W   = 32;
    localparam int CH_W    = 5;
    localparam int ENTRY_W = ADR_W + DAT_W + CH_W;

    typedef enum logic [1:0] {
        DBG_IDLE    = 2'd0,
        DBG_ARMED   = 2'd1,
        DBG_CAPTURE = 2'd2,
        DBG_DONE    = 2'd3
    } dbg_state_e;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [CH_W-1:0]  ch;
    } dbg_entry_t;

    // Out-of-range channel numbers never capture, even though the padded mask bit exists.
    function automatic logic ch_enabled(input logic [31:0] mask,
                                        input logic [CH_W-1:0] ch,
                                        input int unsigned count);
        return (32'(ch) < count) && mask[ch];
    endfunction

endpackage

// File: rtl/fwperiph_dma_dbg_fifo.sv
// Show-ahead circular buffer with flush; the head entry is read asynchronously.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module fwperiph_dma_dbg_fifo
    import fwperiph_dma_dbg_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == LVL_W'(0));
    assign pop_ok_s  = pop_i && !empty_o && !flush_i;
    assign push_ok_s = push_i && (!full_o || pop_ok_s) && !flush_i;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Next-state for pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            level_d  = LVL_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            level_q  <= LVL_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fwperiph_dma_dbg_trace.sv
// DMA debug trace capture: qualifies write-tap events inside one busy window per arm
// and queues them for a valid/ready reader, counting events lost to a full buffer.
module fwperiph_dma_dbg_trace
    import fwperiph_dma_dbg_pkg::*;
#(
    parameter int unsigned ch_count = 1,
    parameter int unsigned depth    = 16,
    parameter int unsigned cnt_w    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADR_W-1:0]        adr,
    input  logic [DAT_W-1:0]        dat_w,
    input  logic [31:0]             we,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic                    dma_busy,
    input  logic                    arm,
    input  logic                    clr,
    input  logic [ch_count-1:0]     ch_mask,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [ADR_W-1:0]        rd_adr,
    output logic [DAT_W-1:0]        rd_dat,
    output logic [CH_W-1:0]         rd_ch,
    output logic [1:0]              state,
    output logic                    overflow,
    output logic [cnt_w-1:0]        drop_cnt,
    output logic [$clog2(depth):0]  level
);
    dbg_state_e     state_q, state_d;
    logic           overflow_q, overflow_d;
    logic [cnt_w-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]    mask_ext_s;
    logic           qual_s, pop_s, drop_s, full_s, empty_s;
    dbg_entry_t     wr_entry_s, head_s;

    assign mask_ext_s = 32'(ch_mask);
    assign qual_s = (we != 32'd0) && ch_enabled(mask_ext_s, ch_sel, ch_count) &&
                    ((state_q == DBG_CAPTURE) || ((state_q == DBG_ARMED) && dma_busy));
    assign pop_s  = !empty_s && rd_ready && !clr;
    assign drop_s = qual_s && full_s && !pop_s && !clr;
    assign wr_entry_s = '{adr: adr, dat: dat_w, ch: ch_sel};

    fwperiph_dma_dbg_fifo #(
        .DEPTH (depth),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (clr),
        .push_i  (qual_s),
        .pop_i   (pop_s),
        .wdata_i (wr_entry_s),
        .rdata_o (head_s),
        .level_o (level),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Head fields are forced to zero while nothing is queued so stale storage never shows.
    assign rd_valid = !empty_s;
    assign rd_adr   = rd_valid ? head_s.adr : 32'd0;
    assign rd_dat   = rd_valid ? head_s.dat : 32'd0;
    assign rd_ch    = rd_valid ? head_s.ch  : 5'd0;
    assign state    = state_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Capture session FSM and drop accounting next-state; clr overrides everything.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            state_d    = DBG_IDLE;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            case (state_q)
                DBG_IDLE:    state_d = arm      ? DBG_ARMED   : DBG_IDLE;
                DBG_ARMED:   state_d = dma_busy ? DBG_CAPTURE : DBG_ARMED;
                DBG_CAPTURE: state_d = dma_busy ? DBG_CAPTURE : DBG_DONE;
                DBG_DONE:    state_d = arm      ? DBG_ARMED   : DBG_DONE;
                default:     state_d = DBG_IDLE;
            endcase
            if (drop_s) begin
                overflow_d = 1'b1;
                drop_cnt_d = (drop_cnt_q == {cnt_w{1'b1}}) ? drop_cnt_q
                                                           : drop_cnt_q + cnt_w'(1);
            end else begin
                overflow_d = overflow_q;
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // State and sticky status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= DBG_IDLE;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwperiph_dma_dbg_trace.sv
// Randomised and directed bench for the DMA debug trace block, checked every cycle
// against a queue-based reference model of the capture rules.
module tb_fwperiph_dma_dbg_trace;
    localparam int CHN = 4;
    localparam int DEP = 16;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clock, reset;
    logic [31:0] adr, dat_w, we;
    logic [4:0]  ch_sel;
    logic        dma_busy, arm, clr, rd_ready;
    logic [CHN-1:0] ch_mask;
    logic        rd_valid;
    logic [31:0] rd_adr, rd_dat;
    logic [4:0]  rd_ch;
    logic [1:0]  state;
    logic        overflow;
    logic [CW-1:0] drop_cnt;
    logic [4:0]  level;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  c;
    } ent_t;

    ent_t mq[$];
    int   m_st;
    bit   m_ov;
    int   m_dc;
    int   n_vec;
    int   n_err;

    fwperiph_dma_dbg_trace #(.ch_count(CHN), .depth(DEP), .cnt_w(CW)) dut (
        .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .we(we),
        .ch_sel(ch_sel), .dma_busy(dma_busy), .arm(arm), .clr(clr),
        .ch_mask(ch_mask), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_adr(rd_adr), .rd_dat(rd_dat), .rd_ch(rd_ch), .state(state),
        .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_st = 0;
        m_ov = 1'b0;
        m_dc = 0;
    endtask

    // One clock of the capture rules applied to the inputs currently driven.
    task automatic model_update();
        bit   pop, qual;
        ent_t e;
        pop  = (mq.size() != 0) && rd_ready;
        qual = (we != 0) && (ch_sel < CHN) && ch_mask[ch_sel[1:0]] &&
               (m_st == 2 || (m_st == 1 && dma_busy));
        if (clr) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (qual) begin
                if (mq.size() < DEP) begin
                    e.a = adr; e.d = dat_w; e.c = ch_sel;
                    mq.push_back(e);
                end else begin
                    m_ov = 1'b1;
                    m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
                end
            end
            if (m_st == 0 && arm) m_st = 1;
            else if (m_st == 1 && dma_busy) m_st = 2;
            else if (m_st == 2 && !dma_busy) m_st = 3;
            else if (m_st == 3 && arm) m_st = 1;
        end
    endtask

    task automatic compare_all();
        chk("state", state, m_st);
        chk("level", level, mq.size());
        chk("rd_valid", rd_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("rd_adr", rd_adr, mq[0].a);
            chk("rd_dat", rd_dat, mq[0].d);
            chk("rd_ch", rd_ch, mq[0].c);
        end
        chk("overflow", overflow, m_ov);
        chk("drop_cnt", drop_cnt, m_dc);
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        compare_all();
        arm = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle_inputs();
        adr = 32'd0; dat_w = 32'd0; we = 32'd0; ch_sel = 5'd0;
        dma_busy = 1'b0; arm = 1'b0; clr = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic event_in(input logic [31:0] a, input logic [31:0] d,
                            input logic [4:0] c, input logic [31:0] w);
        adr = a; dat_w = d; ch_sel = c; we = w;
        step();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, rd_valid, 1'b0);
        chk({tag, "_adr"}, rd_adr, 32'd0);
        chk({tag, "_dat"}, rd_dat, 32'd0);
        chk({tag, "_ch"}, rd_ch, 5'd0);
        chk({tag, "_state"}, state, 2'd0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_drop"}, drop_cnt, 4'd0);
        chk({tag, "_level"}, level, 5'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        idle_inputs();
        ch_mask = 4'b0001;
        reset = 1'b1;
        #2;
        check_zero_outputs("reset");
        #10 reset = 1'b0;
        step();

        // Basic capture of three events in one busy window, then drain in order.
        arm = 1'b1; step();
        dma_busy = 1'b1;
        event_in(32'h100, 32'hA0, 5'd0, 32'hF);
        event_in(32'h104, 32'hA1, 5'd0, 32'hF);
        event_in(32'h108, 32'hA2, 5'd0, 32'hF);
        dma_busy = 1'b0; we = 32'd0;
        step();
        chk("basic_level", level, 5'd3);
        chk("basic_done", state, 2'd3);
        rd_ready = 1'b1;
        repeat (4) step();
        rd_ready = 1'b0;

        // Channel filtering: only ch0 and ch2 enabled; we=0 and ch7 ignored.
        ch_mask = 4'b0101;
        arm = 1'b1; step();
        dma_busy = 1'b1;
        for (int c = 0; c < 4; c++) event_in(32'h200 + c, 32'hB0 + c, 5'(c), 32'h1);
        event_in(32'h210, 32'hBF, 5'd0, 32'h0);
        event_in(32'h214, 32'hBE, 5'd7, 32'hFF);
        chk("filter_level", level, 5'd2);
        chk("filter_head_ch", rd_ch, 5'd0);
        dma_busy = 1'b0; we = 32'd0;
        step();
        rd_ready = 1'b1;
        repeat (3) step();
        rd_ready = 1'b0;

        // Overflow with backpressure, then saturation, then full-with-pop.
        ch_mask = 4'b1111;
        arm = 1'b1; step();
        dma_busy = 1'b1;
        for (int i = 0; i < 20; i++) event_in(32'h1000 + 4 * i, $urandom, 5'(i % 4), 32'h3);
        chk("ovf_level", level, 5'd16);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop", drop_cnt, 4'd4);
        chk("ovf_head", rd_adr, 32'h1000);
        for (int i = 0; i < 16; i++) event_in(32'h2000 + i, $urandom, 5'd1, 32'h1);
        chk("drop_sat", drop_cnt, 4'd15);
        rd_ready = 1'b1;
        event_in(32'h3000, 32'h5A5A, 5'd2, 32'h8);
        chk("fullpop_level", level, 5'd16);
        chk("fullpop_drop", drop_cnt, 4'd15);
        dma_busy = 1'b0; we = 32'd0;
        repeat (18) step();

        // clr during capture with a simultaneous event and pop.
        rd_ready = 1'b0;
        arm = 1'b1; step();
        dma_busy = 1'b1;
        event_in(32'h4000, 32'h1, 5'd3, 32'h1);
        event_in(32'h4004, 32'h2, 5'd3, 32'h1);
        clr = 1'b1; rd_ready = 1'b1;
        event_in(32'h4008, 32'h3, 5'd3, 32'h1);
        chk("clr_state", state, 2'd0);
        chk("clr_level", level, 5'd0);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_drop", drop_cnt, 4'd0);

        // Asynchronous reset pulse between clock edges mid-capture.
        arm = 1'b1; step();
        rd_ready = 1'b0;
        event_in(32'h5000, 32'h9, 5'd1, 32'h1);
        event_in(32'h5004, 32'h8, 5'd1, 32'h1);
        #3 reset = 1'b1;
        #1 check_zero_outputs("areset");
        model_reset();
        idle_inputs();
        #2 reset = 1'b0;
        step();

        // Randomised traffic checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            arm = ($urandom_range(0, 99) < 6);
            clr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) dma_busy = ~dma_busy;
            we = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            adr = $urandom;
            dat_w = $urandom;
            ch_sel = 5'($urandom_range(0, 7));
            if ((i % 500) < 250) rd_ready = ($urandom_range(0, 3) == 0);
            else rd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) ch_mask = 4'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwperiph_dma_dbg_trace.md
Name: fwperiph_dma_dbg_trace

Overview:
Trace capture and readout block for DMA debug. It snoops the DMA write-side debug tap (address, write data, write enables, channel select, busy) and records qualifying write events into a circular buffer. A host or debug agent drains the buffer through a valid/ready read port. This block is the reader/consumer end of the DMA debug interface. An arm/trigger state machine bounds each capture to a single DMA busy window.

Parameters:
ch_count, 1, number of DMA channels; width of ch_mask (1..32)
depth, 16, trace entries; power of two, 2..256
cnt_w, 16, width of the saturating drop counter

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-high reset
adr  input  32  DMA debug tap address
dat_w  input  32  DMA debug tap write data
we  input  32  DMA debug tap write enables; event when any bit is set
ch_sel  input  5  channel issuing the current access
dma_busy  input  1  DMA engine active
arm  input  1  single-cycle pulse: start a new capture session
clr  input  1  single-cycle pulse: flush buffer, clear flags, go IDLE
ch_mask  input  ch_count  per-channel capture enable
rd_valid  output  1  trace entry available
rd_ready  input  1  consumer accepts entry
rd_adr  output  32  entry address
rd_dat  output  32  entry data
rd_ch  output  5  entry channel
state  output  2  FSM state (debug visibility)
overflow  output  1  sticky: an event was dropped because the buffer was full
drop_cnt  output  cnt_w  saturating count of dropped events
level  output  $clog2(depth)+1  current occupancy

Behaviour:
- Reset: all outputs 0; state=IDLE; read/write pointers 0; buffer contents don't-care.
- FSM encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE: arm -> ARMED.
  - ARMED: dma_busy=1 -> CAPTURE. The event in that same cycle is captured.
  - CAPTURE: dma_busy=0 -> DONE. An event in the cycle busy is low is not captured.
  - DONE: arm -> ARMED. Buffer is retained; new entries append.
  - From any state, clr -> IDLE. clr takes priority over arm in the same cycle.
- Event qualification: |we && ch_sel<ch_count && ch_mask[ch_sel] && (state==CAPTURE || (state==ARMED && dma_busy)).
- Push: a qualifying event writes {adr,dat_w,ch_sel} at wr_ptr; wr_ptr advances modulo depth.
- Read port:
  - Show-ahead. rd_valid = (level!=0). rd_adr/rd_dat/rd_ch reflect the head entry.
  - Pop occurs when rd_valid && rd_ready; rd_ptr advances.
  - rd_valid and the head entry must not change while rd_valid=1 and rd_ready=0, except on clr or reset.
- Latency: event sampled at edge N -> rd_valid=1 after edge N (cycle N+1) if the buffer was empty.
- Full (level==depth):
  - Qualifying event with no pop: dropped, overflow<=1, drop_cnt increments and saturates at all-ones.
  - Qualifying event with a simultaneous pop: push accepted, level unchanged, no drop.
- Empty with simultaneous push and rd_ready: no pop (rd_valid was 0); level becomes 1.
- Push and pop in the same cycle with level 1..depth-1: level unchanged.
- clr:
  - Next cycle: level=0, pointers 0, rd_valid=0, overflow=0, drop_cnt=0.
  - An event or pop in the same cycle as clr is discarded.
- arm while in ARMED or CAPTURE: ignored.
- overflow and drop_cnt are cleared only by clr or reset, not by arm.
- Reset asserted mid-capture: immediate return to reset values, asynchronously.
- Storage: flop array or inferred RAM with asynchronous read. Pointers are $clog2(depth) bits wide plus a separate level counter.

Decomposition:
- Shared package fwperiph_dma_dbg_pkg:
  - State encodings DBG_IDLE, DBG_ARMED, DBG_CAPTURE, DBG_DONE.
  - Entry field widths (ADR_W=32, DAT_W=32, CH_W=5).
  - Packed entry struct/width constant ENTRY_W=69.
- One sub-module, fwperiph_dma_dbg_fifo: parameterised show-ahead circular buffer with push/pop/flush, level, and full/empty flags. The FSM, qualification and overflow accounting stay in the top level.

Test Plan:
- Basic capture: reset, arm; dma_busy=1 for 3 cycles with we=0xF and adr=0x100/0x104/0x108, dat_w=0xA0/0xA1/0xA2, ch_sel=0, ch_mask=1 -> level=3. Entries drain in order with rd_ready=1. state ends DONE (3).
- Filtering: ch_count=4, ch_mask=4'b0101. Events on ch 0,1,2,3 and one event with we=0 -> only ch0 and ch2 entries captured. An event with ch_sel=7 is ignored.
- Overflow: depth=16, rd_ready=0, 20 qualifying events -> level=16, overflow=1, drop_cnt=4. The head entry is still the first event.
- Full with pop: buffer full, push and rd_ready=1 in the same cycle -> level stays 16, drop_cnt unchanged, new entry lands last.
- Backpressure stability: rd_valid=1 and rd_ready=0 for 10 cycles while pushes occur -> rd_adr/rd_dat/rd_ch remain constant.
- clr/reset:
  - clr asserted mid-CAPTURE with a simultaneous event -> next cycle state=IDLE, level=0, overflow=0, drop_cnt=0.
  - Async reset pulse between clock edges -> all outputs 0 immediately.
